// File: rtl/ysyx_23060059_lsu.sv
// Memory-access stage: single-beat load/store on the data port, then a one-cycle
// writeback strobe to the WBU carrying the final register/CSR bundle.
module ysyx_23060059_lsu (
  input  logic        clock,
  input  logic        reset,
  input  logic        receive_valid,
  output logic        receive_ready,
  input  logic [4:0]  mem_op,
  input  logic [31:0] addr,
  input  logic [31:0] store_data,
  input  logic [31:0] result,
  input  logic [4:0]  rd,
  input  logic        reg_en,
  input  logic [3:0]  csr_ctrl_i,
  input  logic [31:0] csr_wd,
  input  logic        ebreak,
  input  logic [95:0] trace_i,
  output logic        mem_valid,
  input  logic        mem_ready,
  output logic        mem_wen,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic [3:0]  mem_wstrb,
  input  logic        mem_rvalid,
  input  logic [31:0] mem_rdata,
  output logic        send_valid,
  output logic [4:0]  rd_o,
  output logic        reg_en_o,
  output logic [3:0]  csr_ctrl_o,
  output logic [31:0] csr_wd_o,
  output logic        ebreak_o,
  output logic [95:0] trace_o,
  output logic [31:0] wd_o
);

  typedef enum logic [1:0] {StIdle, StReq, StWait, StSend} state_e;

  state_e      state_q;
  logic [4:0]  op_q;
  logic [1:0]  off_q;
  logic [31:0] result_q;
  logic [4:0]  rd_q;
  logic        reg_en_q;
  logic [3:0]  csr_ctrl_q;
  logic [31:0] csr_wd_q;
  logic        ebreak_q;
  logic [95:0] trace_q;

  logic [31:0] wdata_d;
  logic [3:0]  wstrb_d;
  logic [31:0] load_word;
  logic [31:0] load_data;
  logic        is_load_q;

  assign receive_ready = (state_q == StIdle);
  assign is_load_q     = op_q[4] & ~op_q[3];

  // Store lane placement from the incoming (not yet latched) address.
  always_comb begin
    wdata_d = store_data << {addr[1:0], 3'b000};
    case (mem_op[1:0])
      2'b00:   wstrb_d = 4'b0001 << addr[1:0];
      2'b01:   wstrb_d = 4'b0011 << addr[1:0];
      default: wstrb_d = 4'b1111;
    endcase
  end

  // Bytes shifted in from beyond the word are zero before extension.
  always_comb begin
    load_word = mem_rdata >> {off_q, 3'b000};
    case (op_q[2:0])
      3'b000:  load_data = {{24{load_word[7]}}, load_word[7:0]};
      3'b100:  load_data = {24'd0, load_word[7:0]};
      3'b001:  load_data = {{16{load_word[15]}}, load_word[15:0]};
      3'b101:  load_data = {16'd0, load_word[15:0]};
      default: load_data = load_word;
    endcase
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q    <= StIdle;
      op_q       <= '0;
      off_q      <= '0;
      result_q   <= '0;
      rd_q       <= '0;
      reg_en_q   <= 1'b0;
      csr_ctrl_q <= '0;
      csr_wd_q   <= '0;
      ebreak_q   <= 1'b0;
      trace_q    <= '0;
      mem_valid  <= 1'b0;
      mem_wen    <= 1'b0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
      mem_wstrb  <= '0;
      send_valid <= 1'b0;
      rd_o       <= '0;
      reg_en_o   <= 1'b0;
      csr_ctrl_o <= '0;
      csr_wd_o   <= '0;
      ebreak_o   <= 1'b0;
      trace_o    <= '0;
      wd_o       <= '0;
    end else begin
      send_valid <= 1'b0;
      case (state_q)
        StIdle: begin
          if (receive_valid) begin
            op_q       <= mem_op;
            off_q      <= addr[1:0];
            result_q   <= result;
            rd_q       <= rd;
            reg_en_q   <= reg_en;
            csr_ctrl_q <= csr_ctrl_i;
            csr_wd_q   <= csr_wd;
            ebreak_q   <= ebreak;
            trace_q    <= trace_i;
            if (mem_op[4] || mem_op[3]) begin
              state_q   <= StReq;
              mem_valid <= 1'b1;
              mem_wen   <= mem_op[3];
              mem_addr  <= {addr[31:2], 2'b00};
              mem_wdata <= mem_op[3] ? wdata_d : 32'd0;
              mem_wstrb <= mem_op[3] ? wstrb_d : 4'd0;
            end else begin
              // Non-memory ops bypass the latch and publish straight to the WBU.
              state_q    <= StSend;
              send_valid <= 1'b1;
              rd_o       <= rd;
              reg_en_o   <= reg_en;
              csr_ctrl_o <= csr_ctrl_i;
              csr_wd_o   <= csr_wd;
              ebreak_o   <= ebreak;
              trace_o    <= trace_i;
              wd_o       <= result;
            end
          end
        end
        StReq: begin
          if (mem_ready) begin
            mem_valid <= 1'b0;
            state_q   <= StWait;
          end
        end
        StWait: begin
          if (mem_rvalid) begin
            state_q    <= StSend;
            send_valid <= 1'b1;
            rd_o       <= rd_q;
            reg_en_o   <= reg_en_q;
            csr_ctrl_o <= csr_ctrl_q;
            csr_wd_o   <= csr_wd_q;
            ebreak_o   <= ebreak_q;
            trace_o    <= trace_q;
            wd_o       <= is_load_q ? load_data : result_q;
          end
        end
        StSend:  state_q <= StIdle;
        default: state_q <= StIdle;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_23060059_lsu.sv
// Directed bench for the LSU: reset, ALU passthrough, loads, stores, stalls, mid-op reset.
module tb_ysyx_23060059_lsu;

  logic        clock = 1'b0;
  logic        reset = 1'b0;
  logic        receive_valid = 1'b0;
  logic        receive_ready;
  logic [4:0]  mem_op = '0;
  logic [31:0] addr = '0;
  logic [31:0] store_data = '0;
  logic [31:0] result = '0;
  logic [4:0]  rd = '0;
  logic        reg_en = 1'b0;
  logic [3:0]  csr_ctrl_i = '0;
  logic [31:0] csr_wd = '0;
  logic        ebreak = 1'b0;
  logic [95:0] trace_i = '0;
  logic        mem_valid;
  logic        mem_ready = 1'b0;
  logic        mem_wen;
  logic [31:0] mem_addr;
  logic [31:0] mem_wdata;
  logic [3:0]  mem_wstrb;
  logic        mem_rvalid = 1'b0;
  logic [31:0] mem_rdata = '0;
  logic        send_valid;
  logic [4:0]  rd_o;
  logic        reg_en_o;
  logic [3:0]  csr_ctrl_o;
  logic [31:0] csr_wd_o;
  logic        ebreak_o;
  logic [95:0] trace_o;
  logic [31:0] wd_o;

  int checks = 0;
  int failures = 0;

  always #5 clock = ~clock;

  ysyx_23060059_lsu dut (
    .clock(clock), .reset(reset), .receive_valid(receive_valid),
    .receive_ready(receive_ready), .mem_op(mem_op), .addr(addr), .store_data(store_data),
    .result(result), .rd(rd), .reg_en(reg_en), .csr_ctrl_i(csr_ctrl_i), .csr_wd(csr_wd),
    .ebreak(ebreak), .trace_i(trace_i), .mem_valid(mem_valid), .mem_ready(mem_ready),
    .mem_wen(mem_wen), .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
    .mem_rvalid(mem_rvalid), .mem_rdata(mem_rdata), .send_valid(send_valid), .rd_o(rd_o),
    .reg_en_o(reg_en_o), .csr_ctrl_o(csr_ctrl_o), .csr_wd_o(csr_wd_o), .ebreak_o(ebreak_o),
    .trace_o(trace_o), .wd_o(wd_o)
  );

  // Presents one bundle for exactly one rising edge; returns #1 after that edge.
  task automatic issue(input logic [4:0] op, input logic [31:0] a, input logic [31:0] sd,
                       input logic [31:0] res, input logic [4:0] r);
    mem_op = op; addr = a; store_data = sd; result = res; rd = r; reg_en = 1'b1;
    receive_valid = 1'b1;
    @(posedge clock); #1;
    receive_valid = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (receive_ready !== 1'b1 || send_valid !== 1'b0 || mem_valid !== 1'b0 ||
          mem_wen !== 1'b0 || mem_wstrb !== 4'd0 || mem_addr !== 32'd0 ||
          mem_wdata !== 32'd0 || wd_o !== 32'd0 || rd_o !== 5'd0 || trace_o !== 96'd0) begin
        failures++;
        $display("FAIL reset_state cyc%0d: ready=%b send=%b mval=%b strb=%h addr=%h wd=%h",
                 i, receive_ready, send_valid, mem_valid, mem_wstrb, mem_addr, wd_o);
      end
    end
    reset = 1'b1;
    @(negedge clock);
    checks++;
    if (receive_ready !== 1'b1 || send_valid !== 1'b0 || mem_valid !== 1'b0) begin
      failures++;
      $display("FAIL reset_release: ready=%b send=%b mval=%b expected 1 0 0",
               receive_ready, send_valid, mem_valid);
    end
  endtask

  task automatic test_alu();
    trace_i = {32'h8000_0010, 32'h8000_0014, 32'h0000_0013};
    csr_ctrl_i = 4'b1010; csr_wd = 32'hA5A5_0001; ebreak = 1'b1;
    issue(5'b00_000, 32'h0, 32'h0, 32'h1234_5678, 5'd5);
    @(negedge clock);
    checks++;
    if (send_valid !== 1'b1 || wd_o !== 32'h1234_5678 || rd_o !== 5'd5 || reg_en_o !== 1'b1 ||
        receive_ready !== 1'b0) begin
      failures++;
      $display("FAIL alu_send: send=%b wd=%h rd=%0d ren=%b ready=%b exp 1 12345678 5 1 0",
               send_valid, wd_o, rd_o, reg_en_o, receive_ready);
    end
    checks++;
    if (csr_ctrl_o !== 4'b1010 || csr_wd_o !== 32'hA5A5_0001 || ebreak_o !== 1'b1 ||
        trace_o !== {32'h8000_0010, 32'h8000_0014, 32'h0000_0013}) begin
      failures++;
      $display("FAIL alu_sideband: csr=%h csrwd=%h ebreak=%b trace=%h",
               csr_ctrl_o, csr_wd_o, ebreak_o, trace_o);
    end
    result = 32'hFFFF_FFFF; rd = 5'd9;
    csr_ctrl_i = '0; csr_wd = '0; ebreak = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (send_valid !== 1'b0 || wd_o !== 32'h1234_5678 || rd_o !== 5'd5 ||
          receive_ready !== 1'b1) begin
        failures++;
        $display("FAIL alu_hold cyc%0d: send=%b wd=%h rd=%0d ready=%b exp 0 12345678 5 1",
                 i, send_valid, wd_o, rd_o, receive_ready);
      end
    end
  endtask

  task automatic test_loads();
    logic [2:0]  f3  [6] = '{3'b000, 3'b100, 3'b001, 3'b010, 3'b101, 3'b001};
    logic [31:0] ad  [6] = '{32'h8000_0003, 32'h8000_0003, 32'h8000_0002, 32'h8000_0000,
                             32'h8000_0000, 32'h8000_0003};
    logic [31:0] exp [6] = '{32'hFFFF_FF80, 32'h0000_0080, 32'hFFFF_80FF, 32'h80FF_7F01,
                             32'h0000_7F01, 32'h0000_0080};
    for (int k = 0; k < 6; k++) begin
      issue({2'b10, f3[k]}, ad[k], 32'hFFFF_FFFF, 32'hDEAD_0000, 5'd7);
      @(negedge clock);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0000 || mem_wen !== 1'b0 ||
          mem_wstrb !== 4'd0) begin
        failures++;
        $display("FAIL load_req%0d: mval=%b addr=%h wen=%b strb=%b exp 1 80000000 0 0000",
                 k, mem_valid, mem_addr, mem_wen, mem_wstrb);
      end
      mem_ready = 1'b1;
      @(posedge clock); #1;
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'h80FF_7F01;
      @(posedge clock); #1;
      mem_rvalid = 1'b0; mem_rdata = 32'h0;
      @(negedge clock);
      checks++;
      if (send_valid !== 1'b1 || wd_o !== exp[k] || rd_o !== 5'd7) begin
        failures++;
        $display("FAIL load_wd%0d: send=%b wd=%h rd=%0d exp 1 %h 7",
                 k, send_valid, wd_o, rd_o, exp[k]);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_stores();
    logic [2:0]  f3  [3] = '{3'b001, 3'b000, 3'b010};
    logic [31:0] ad  [3] = '{32'h8000_0002, 32'h8000_0101, 32'h8000_0200};
    logic [31:0] sd  [3] = '{32'h0000_BEEF, 32'h0000_00AB, 32'hCAFE_BABE};
    logic [31:0] ea  [3] = '{32'h8000_0000, 32'h8000_0100, 32'h8000_0200};
    logic [31:0] ewd [3] = '{32'hBEEF_0000, 32'h0000_AB00, 32'hCAFE_BABE};
    logic [3:0]  est [3] = '{4'b1100, 4'b0010, 4'b1111};
    for (int k = 0; k < 3; k++) begin
      issue({2'b01, f3[k]}, ad[k], sd[k], 32'h11 + k, 5'd3);
      @(negedge clock);
      checks++;
      if (mem_valid !== 1'b1 || mem_wen !== 1'b1 || mem_addr !== ea[k] ||
          mem_wdata !== ewd[k] || mem_wstrb !== est[k]) begin
        failures++;
        $display("FAIL store_req%0d: mval=%b wen=%b addr=%h wdata=%h strb=%b exp 1 1 %h %h %b",
                 k, mem_valid, mem_wen, mem_addr, mem_wdata, mem_wstrb, ea[k], ewd[k], est[k]);
      end
      mem_ready = 1'b1;
      @(posedge clock); #1;
      mem_ready = 1'b0; mem_rvalid = 1'b1; mem_rdata = 32'hFFFF_FFFF;
      @(posedge clock); #1;
      mem_rvalid = 1'b0;
      @(negedge clock);
      checks++;
      if (send_valid !== 1'b1 || wd_o !== 32'h11 + k) begin
        failures++;
        $display("FAIL store_wd%0d: send=%b wd=%h exp 1 %h", k, send_valid, wd_o, 32'h11 + k);
      end
      @(negedge clock);
    end
  endtask

  task automatic test_stall();
    int sends = 0;
    issue(5'b10_010, 32'h8000_0040, 32'h0, 32'h0, 5'd12);
    // rvalid during REQ and in the handshake cycle must be ignored.
    mem_rvalid = 1'b1; mem_rdata = 32'hDEAD_BEEF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      checks++;
      if (mem_valid !== 1'b1 || mem_addr !== 32'h8000_0040 || mem_wen !== 1'b0 ||
          mem_wstrb !== 4'd0 || receive_ready !== 1'b0 || send_valid !== 1'b0) begin
        failures++;
        $display("FAIL stall_req%0d: mval=%b addr=%h ready=%b send=%b exp 1 80000040 0 0",
                 i, mem_valid, mem_addr, receive_ready, send_valid);
      end
    end
    mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0; mem_rvalid = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(negedge clock);
      checks++;
      if (mem_valid !== 1'b0 || send_valid !== 1'b0 || receive_ready !== 1'b0) begin
        failures++;
        $display("FAIL stall_wait%0d: mval=%b send=%b ready=%b exp 0 0 0",
                 i, mem_valid, send_valid, receive_ready);
      end
    end
    mem_rvalid = 1'b1; mem_rdata = 32'hCAFE_F00D;
    @(posedge clock); #1;
    mem_rvalid = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 5; i++) begin
      @(negedge clock);
      if (send_valid === 1'b1) sends++;
    end
    checks++;
    if (sends != 1 || wd_o !== 32'hCAFE_F00D || rd_o !== 5'd12) begin
      failures++;
      $display("FAIL stall_send: sends=%0d wd=%h rd=%0d exp 1 cafef00d 12", sends, wd_o, rd_o);
    end
  endtask

  task automatic test_reset_mid();
    int sends = 0;
    issue(5'b10_010, 32'h8000_0080, 32'h0, 32'h0, 5'd4);
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || receive_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_req_async: mval=%b ready=%b exp 0 1", mem_valid, receive_ready);
    end
    @(negedge clock);
    reset = 1'b1;
    issue(5'b10_010, 32'h8000_0080, 32'h0, 32'h0, 5'd4);
    mem_ready = 1'b1;
    @(posedge clock); #1;
    mem_ready = 1'b0;
    @(negedge clock);
    reset = 1'b0;
    #1;
    checks++;
    if (mem_valid !== 1'b0 || send_valid !== 1'b0 || receive_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_wait: mval=%b send=%b ready=%b exp 0 0 1",
               mem_valid, send_valid, receive_ready);
    end
    mem_rvalid = 1'b1; mem_rdata = 32'h1234_0000;
    @(negedge clock);
    reset = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clock);
      if (send_valid === 1'b1) sends++;
    end
    mem_rvalid = 1'b0;
    checks++;
    if (sends != 0) begin
      failures++;
      $display("FAIL reset_no_send: sends=%0d exp 0", sends);
    end
    issue(5'b00_000, 32'h0, 32'h0, 32'h0000_ABCD, 5'd8);
    @(negedge clock);
    checks++;
    if (send_valid !== 1'b1 || wd_o !== 32'h0000_ABCD || rd_o !== 5'd8) begin
      failures++;
      $display("FAIL reset_then_alu: send=%b wd=%h rd=%0d exp 1 0000abcd 8",
               send_valid, wd_o, rd_o);
    end
    @(negedge clock);
  endtask

  task automatic test_back_to_back();
    mem_op = 5'b00_000; result = 32'h55; rd = 5'd1;
    receive_valid = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clock);
      checks++;
      if (send_valid !== ((i % 2) == 0)) begin
        failures++;
        $display("FAIL b2b_cyc%0d: send=%b exp %b", i, send_valid, (i % 2) == 0);
      end
    end
    receive_valid = 1'b0;
    @(negedge clock);
    checks++;
    if (send_valid !== 1'b0 || receive_ready !== 1'b1 || wd_o !== 32'h55) begin
      failures++;
      $display("FAIL b2b_end: send=%b ready=%b wd=%h exp 0 1 55", send_valid, receive_ready, wd_o);
    end
  endtask

  initial begin
    test_reset();
    test_alu();
    test_loads();
    test_stores();
    test_stall();
    test_reset_mid();
    test_back_to_back();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/ysyx_23060059_lsu.md
# ysyx_23060059_lsu
Memory-access stage that feeds the register writeback stage (WBU). Accepts one instruction bundle from the execute stage and, for loads and stores, runs a single-beat transaction on the data-memory port: word-aligned address, byte strobes, load alignment and sign extension. Then emits a one-cycle `send_valid` strobe with the final writeback bundle. The WBU has no ready signal, so this block is the transmitter side of the `receive_valid` writeback interface.

## Interface
- Parameters: none; datapath fixed at 32 bits.
- `clock`  in  1  single clock, rising edge.
- `reset`  in  1  asynchronous, active-low reset.
- `receive_valid`  in  1  execute-stage bundle valid.
- `receive_ready`  out  1  high only in IDLE.
- `mem_op`  in  5  `{ren, wen, funct3[2:0]}`.
- `addr`  in  32  byte address of the load or store.
- `store_data`  in  32  store source (rs2), low-aligned.
- `result`  in  32  ALU/CSR result; writeback data for non-loads.
- `rd`  in  5  destination GPR.
- `reg_en`  in  1  GPR write enable.
- `csr_ctrl_i`  in  4  `{csreg_en, ecall, csr_rd[1:0]}`.
- `csr_wd`  in  32  CSR write data.
- `ebreak`  in  1  ebreak flag.
- `trace_i`  in  96  `{pc, pc_next, instruction}`.
- `mem_valid`  out  1  memory request valid.
- `mem_ready`  in  1  memory request accepted.
- `mem_wen`  out  1  1 = write.
- `mem_addr`  out  32  `{addr[31:2], 2'b00}`.
- `mem_wdata`  out  32  store data shifted to byte lane.
- `mem_wstrb`  out  4  byte strobes; 0 for loads.
- `mem_rvalid`  in  1  response or ack; also acknowledges stores.
- `mem_rdata`  in  32  read word.
- `send_valid`  out  1  one-cycle strobe to the WBU.
- `rd_o`, `reg_en_o`, `csr_ctrl_o`, `csr_wd_o`, `ebreak_o`, `trace_o`  out  5/1/4/32/1/96  registered copies of the latched inputs.
- `wd_o`  out  32  GPR writeback data.

## Operation
- States: IDLE, REQ, WAIT, SEND.
- **IDLE:** on `receive_valid`, latch every input. If `ren` or `wen` is set, go to REQ; otherwise go to SEND.
- **REQ:** drive `mem_valid`=1 with `mem_addr`, `mem_wen`, `mem_wdata`, `mem_wstrb`. All request fields stay stable until `mem_ready`, then go to WAIT.
- **WAIT:** the first `mem_rvalid` goes to SEND and captures load data. Store acks ignore `mem_rdata`.
- **SEND:** `send_valid`=1 for exactly one cycle, then return to IDLE. WBU outputs hold their values until the next SEND.
- Byte offset `off` = `addr[1:0]`.
  - Stores: `mem_wdata` = `store_data << 8*off`.
  - Strobes: sb = `4'b0001<<off`, sh = `4'b0011<<off`, sw = `4'b1111`.
- Loads: `w` = `mem_rdata >> 8*off`.
  - lb (000): `w[7:0]` sign-extended; lbu (100): zero-extended.
  - lh (001): `w[15:0]` sign-extended; lhu (101): zero-extended.
  - lw (010) and all other funct3 values: `w`.
- No misalignment trap. Bytes beyond the word (for example lh at `off`=3) read as 0 before extension, and strobes are truncated to 4 bits.
- `wd_o` = load data when `ren`=1 and `wen`=0; otherwise `result`. If both `ren` and `wen` are set, the access is a store.

## Timing
- Reset (`reset`=0, asynchronous):
  - State IDLE; `receive_ready`=1.
  - `send_valid`, `mem_valid`, `mem_wen`, `mem_wstrb` = 0; all data/address outputs = 0.
- Non-memory op accepted at edge T: `send_valid` is high in cycle T+1. Throughput is one op per 2 cycles.
- Memory op accepted at edge T:
  - `mem_valid` rises in cycle T+1.
  - `mem_rvalid` is sampled from the cycle after the `mem_ready` handshake; `mem_rvalid` in the handshake cycle itself is ignored.
  - `send_valid` is asserted in the cycle after `mem_rvalid`. Minimum latency is 4 cycles.
- `mem_rvalid` in IDLE, REQ or SEND is ignored. `receive_valid` outside IDLE is ignored.
- Reset mid-transaction drops it immediately: `mem_valid` falls asynchronously and no `send_valid` is issued for the dropped instruction.

## Test plan
- Reset held low 3 cycles, then released: all outputs 0 and `receive_ready`=1 throughout. First `receive_valid` is accepted.
- Non-memory op with `result`=0x12345678, `rd`=5, `reg_en`=1: `send_valid`=1 exactly one cycle later with `wd_o`=0x12345678 and `rd_o`=5. Outputs hold afterwards while `send_valid`=0.
- Loads with `mem_rdata`=0x80FF7F01:
  - lb @0x80000003 gives `mem_addr`=0x80000000 and `wd_o`=0xFFFFFF80.
  - lbu @0x80000003 gives `wd_o`=0x00000080.
  - lh @0x80000002 gives `wd_o`=0xFFFF80FF.
  - lw @0x80000000 gives `wd_o`=0x80FF7F01.
- sh @0x80000002 with `store_data`=0x0000BEEF and `result`=0x11: `mem_addr`=0x80000000, `mem_wstrb`=1100, `mem_wdata`=0xBEEF0000. `wd_o`=0x11 after the ack.
- `mem_ready` held low 3 cycles, then the response is delayed 2 cycles: request fields stay stable, `receive_ready`=0, and exactly one `send_valid` is issued.
- Reset asserted in WAIT: `mem_valid`=0 and no `send_valid`. A following ALU op completes with 2-cycle latency.
